rs_multi_entry: RTL and testbench

- Parametrised out-of-order reservation station, successor to the one-entry-per-FU station.
- NUM_ENTRIES shared entries serve NUM_FU_TYPES functional-unit classes, with NUM_CDB-wide tag wakeup and oldest-first (ROB-age) issue per FU class.
- Sits between dispatch (decoder / map table / free list) and the FU issue stage.
- Squashes on branch rollback using ROB-relative age.

---
 rtl/rs_multi_entry_if.sv | 54 +++++
 rtl/rs_multi_entry.sv | 188 ++++++++++++++++++
 tb/tb_rs_multi_entry.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_multi_entry_if.sv
// rs_multi_entry_if: dispatch, wakeup, rollback and issue signals of the reservation station.
// The master side (dispatch/ROB/FU control) drives requests; the slave side is the station.
interface rs_multi_entry_if #(
  parameter int unsigned NUM_ENTRIES  = 8,
  parameter int unsigned NUM_FU_TYPES = 4,
  parameter int unsigned NUM_CDB      = 2,
  parameter int unsigned ROB_IDX_W    = 5,
  parameter int unsigned PR_IDX_W     = 6,
  parameter int unsigned PAYLOAD_W    = 64
);
  localparam int unsigned FuW  = (NUM_FU_TYPES > 1) ? $clog2(NUM_FU_TYPES) : 1;
  localparam int unsigned OccW = $clog2(NUM_ENTRIES + 1);

  logic                              en;
  logic                              dispatch_en;
  logic [FuW-1:0]                    dispatch_fu;
  logic [ROB_IDX_W-1:0]              dispatch_rob_idx;
  logic [PR_IDX_W-1:0]               dispatch_T_idx;
  logic [PR_IDX_W-1:0]               dispatch_T1_idx;
  logic [PR_IDX_W-1:0]               dispatch_T2_idx;
  logic                              dispatch_T1_ready;
  logic                              dispatch_T2_ready;
  logic [PAYLOAD_W-1:0]              dispatch_payload;
  logic                              dispatch_ready;
  logic [NUM_CDB-1:0]                cdb_valid;
  logic [NUM_CDB*PR_IDX_W-1:0]       cdb_T_idx;
  logic [ROB_IDX_W-1:0]              rob_head;
  logic                              rollback_en;
  logic [ROB_IDX_W-1:0]              rollback_idx;
  logic [NUM_FU_TYPES-1:0]           fu_ready;
  logic [NUM_FU_TYPES-1:0]           issue_valid;
  logic [NUM_FU_TYPES*ROB_IDX_W-1:0] issue_rob_idx;
  logic [NUM_FU_TYPES*PR_IDX_W-1:0]  issue_T_idx;
  logic [NUM_FU_TYPES*PR_IDX_W-1:0]  issue_T1_idx;
  logic [NUM_FU_TYPES*PR_IDX_W-1:0]  issue_T2_idx;
  logic [NUM_FU_TYPES*PAYLOAD_W-1:0] issue_payload;
  logic [OccW-1:0]                   occupancy;

  modport master (
    output en, dispatch_en, dispatch_fu, dispatch_rob_idx, dispatch_T_idx, dispatch_T1_idx,
           dispatch_T2_idx, dispatch_T1_ready, dispatch_T2_ready, dispatch_payload, cdb_valid,
           cdb_T_idx, rob_head, rollback_en, rollback_idx, fu_ready,
    input  dispatch_ready, issue_valid, issue_rob_idx, issue_T_idx, issue_T1_idx, issue_T2_idx,
           issue_payload, occupancy
  );

  modport slave (
    input  en, dispatch_en, dispatch_fu, dispatch_rob_idx, dispatch_T_idx, dispatch_T1_idx,
           dispatch_T2_idx, dispatch_T1_ready, dispatch_T2_ready, dispatch_payload, cdb_valid,
           cdb_T_idx, rob_head, rollback_en, rollback_idx, fu_ready,
    output dispatch_ready, issue_valid, issue_rob_idx, issue_T_idx, issue_T1_idx, issue_T2_idx,
           issue_payload, occupancy
  );
endinterface

// File: rtl/rs_multi_entry.sv
// rs_multi_entry: shared-entry reservation station with CDB tag wakeup, oldest-first (ROB age)
// issue per FU class and age-based squash on rollback.
// Build option: define RS_CDB_BYPASS_EN to let a same-cycle CDB match make an entry
// issue-eligible; otherwise only latched ready bits count (shorter CDB-to-select path).
module rs_multi_entry #(
  parameter int unsigned NUM_ENTRIES  = 8,
  parameter int unsigned NUM_FU_TYPES = 4,
  parameter int unsigned NUM_CDB      = 2,
  parameter int unsigned ROB_IDX_W    = 5,
  parameter int unsigned PR_IDX_W     = 6,
  parameter int unsigned PAYLOAD_W    = 64
) (
  input logic             clock,
  input logic             reset,
  rs_multi_entry_if.slave bus_io
);
  localparam int unsigned FuW  = (NUM_FU_TYPES > 1) ? $clog2(NUM_FU_TYPES) : 1;
  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned OccW = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [FuW-1:0]         fu_q  [NUM_ENTRIES];
  logic [FuW-1:0]         fu_d  [NUM_ENTRIES];
  logic [ROB_IDX_W-1:0]   rob_q [NUM_ENTRIES];
  logic [ROB_IDX_W-1:0]   rob_d [NUM_ENTRIES];
  logic [PR_IDX_W-1:0]    t_q   [NUM_ENTRIES];
  logic [PR_IDX_W-1:0]    t_d   [NUM_ENTRIES];
  logic [PR_IDX_W-1:0]    t1_q  [NUM_ENTRIES];
  logic [PR_IDX_W-1:0]    t1_d  [NUM_ENTRIES];
  logic [PR_IDX_W-1:0]    t2_q  [NUM_ENTRIES];
  logic [PR_IDX_W-1:0]    t2_d  [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   pay_q [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   pay_d [NUM_ENTRIES];
  logic [OccW-1:0]        occ_q, occ_d;

  logic [ROB_IDX_W-1:0]    rb_age;
  logic [ROB_IDX_W-1:0]    age     [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  hit1, hit2, squash, elig, freed;
  logic [NUM_FU_TYPES-1:0] sel_valid, fire;
  logic [IdxW-1:0]         sel_idx [NUM_FU_TYPES];
  logic                    disp_hit1, disp_hit2, alloc_found, do_disp;
  logic [IdxW-1:0]         alloc_idx;

  function automatic logic cdb_hit(input logic [PR_IDX_W-1:0]         tag,
                                   input logic [NUM_CDB-1:0]          vld,
                                   input logic [NUM_CDB*PR_IDX_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < int'(NUM_CDB); c++) begin
      if (vld[c] && (tags[c*PR_IDX_W +: PR_IDX_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Per-entry age, CDB match, squash and issue eligibility.
  always_comb begin
    rb_age    = bus_io.rollback_idx - bus_io.rob_head;
    disp_hit1 = cdb_hit(bus_io.dispatch_T1_idx, bus_io.cdb_valid, bus_io.cdb_T_idx);
    disp_hit2 = cdb_hit(bus_io.dispatch_T2_idx, bus_io.cdb_valid, bus_io.cdb_T_idx);
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      age[i]    = rob_q[i] - bus_io.rob_head;
      hit1[i]   = cdb_hit(t1_q[i], bus_io.cdb_valid, bus_io.cdb_T_idx);
      hit2[i]   = cdb_hit(t2_q[i], bus_io.cdb_valid, bus_io.cdb_T_idx);
      squash[i] = bus_io.rollback_en && busy_q[i] && (age[i] >= rb_age);
`ifdef RS_CDB_BYPASS_EN
      elig[i]   = busy_q[i] && !squash[i] && (rdy1_q[i] || hit1[i]) && (rdy2_q[i] || hit2[i]);
`else
      elig[i]   = busy_q[i] && !squash[i] && rdy1_q[i] && rdy2_q[i];
`endif
    end
  end

  // Oldest-first select per FU class; strict '<' keeps the lowest index on equal age.
  always_comb begin
    logic [ROB_IDX_W-1:0] best_age;
    best_age = '0;
    for (int f = 0; f < int'(NUM_FU_TYPES); f++) begin
      sel_valid[f] = 1'b0;
      sel_idx[f]   = '0;
      best_age     = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (elig[i] && (fu_q[i] == FuW'(f)) && (!sel_valid[f] || (age[i] < best_age))) begin
          sel_valid[f] = 1'b1;
          sel_idx[f]   = IdxW'(i);
          best_age     = age[i];
        end
      end
    end
  end

  // Issue outputs, handshake and the entries freed by it.
  always_comb begin
    fire  = sel_valid & bus_io.fu_ready & {NUM_FU_TYPES{bus_io.en}};
    freed = '0;
    for (int f = 0; f < int'(NUM_FU_TYPES); f++) begin
      bus_io.issue_valid[f]                           = sel_valid[f];
      bus_io.issue_rob_idx[f*ROB_IDX_W +: ROB_IDX_W]  = rob_q[sel_idx[f]];
      bus_io.issue_T_idx[f*PR_IDX_W +: PR_IDX_W]      = t_q[sel_idx[f]];
      bus_io.issue_T1_idx[f*PR_IDX_W +: PR_IDX_W]     = t1_q[sel_idx[f]];
      bus_io.issue_T2_idx[f*PR_IDX_W +: PR_IDX_W]     = t2_q[sel_idx[f]];
      bus_io.issue_payload[f*PAYLOAD_W +: PAYLOAD_W]  = pay_q[sel_idx[f]];
      if (fire[f]) freed[sel_idx[f]] = 1'b1;
    end
  end

  // Allocation: lowest free entry, gated by the registered occupancy.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (!busy_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IdxW'(i);
      end
    end
    bus_io.dispatch_ready = (occ_q < OccW'(NUM_ENTRIES)) && !bus_io.rollback_en;
    bus_io.occupancy      = occ_q;
    do_disp = bus_io.en && bus_io.dispatch_en && bus_io.dispatch_ready && alloc_found;
  end

  // Next state: free/squash, wakeup latch, dispatch write and occupancy update.
  always_comb begin
    busy_d = busy_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    fu_d   = fu_q;
    rob_d  = rob_q;
    t_d    = t_q;
    t1_d   = t1_q;
    t2_d   = t2_q;
    pay_d  = pay_q;
    occ_d  = occ_q;
    if (bus_io.en) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (busy_q[i]) begin
          if (squash[i] || freed[i]) begin
            busy_d[i] = 1'b0;
            occ_d     = occ_d - OccW'(1);
          end else begin
            rdy1_d[i] = rdy1_q[i] | hit1[i];
            rdy2_d[i] = rdy2_q[i] | hit2[i];
          end
        end
      end
      if (do_disp) begin
        busy_d[alloc_idx] = 1'b1;
        fu_d[alloc_idx]   = bus_io.dispatch_fu;
        rob_d[alloc_idx]  = bus_io.dispatch_rob_idx;
        t_d[alloc_idx]    = bus_io.dispatch_T_idx;
        t1_d[alloc_idx]   = bus_io.dispatch_T1_idx;
        t2_d[alloc_idx]   = bus_io.dispatch_T2_idx;
        rdy1_d[alloc_idx] = bus_io.dispatch_T1_ready | disp_hit1;
        rdy2_d[alloc_idx] = bus_io.dispatch_T2_ready | disp_hit2;
        pay_d[alloc_idx]  = bus_io.dispatch_payload;
        occ_d             = occ_d + OccW'(1);
      end
    end
  end

  // Entry and occupancy registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        fu_q[i]  <= '0;
        rob_q[i] <= '0;
        t_q[i]   <= '0;
        t1_q[i]  <= '0;
        t2_q[i]  <= '0;
        pay_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      occ_q  <= occ_d;
      fu_q   <= fu_d;
      rob_q  <= rob_d;
      t_q    <= t_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      pay_q  <= pay_d;
    end
  end
endmodule

// File: tb/tb_rs_multi_entry.sv
// tb_rs_multi_entry: directed scenarios plus random traffic against a queue-of-ops reference
// model; expected per-cycle status and presented ops go to queues checked by a monitor.
module tb_rs_multi_entry;
  localparam int NE = 8;
  localparam int NF = 4;
  localparam int NC = 2;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int DW = 64;
  localparam int FW = RW + 3 * PW + DW;
`ifdef RS_CDB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rs_multi_entry_if bus ();
  rs_multi_entry dut (.clock(clock), .reset(reset), .bus_io(bus));

  typedef struct {
    logic [1:0]    fu;
    logic [RW-1:0] rob;
    logic [PW-1:0] t, t1, t2;
    logic          r1, r2;
    logic [DW-1:0] pay;
  } op_t;
  typedef struct {
    bit            chk;
    int            cyc;
    logic [NF-1:0] vld;
    logic [3:0]    occ;
    logic          drdy;
  } cyc_exp_t;
  typedef struct {
    int            cyc;
    int            f;
    logic [FW-1:0] fields;
  } iss_exp_t;

  op_t      model_q[$];
  cyc_exp_t cyc_q[$];
  iss_exp_t iss_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp,
                     input int cyc);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] age(input logic [RW-1:0] x);
    return x - bus.rob_head;
  endfunction

  function automatic bit hit(input logic [PW-1:0] tag);
    for (int c = 0; c < NC; c++) if (bus.cdb_valid[c] && bus.cdb_T_idx[c*PW +: PW] == tag) return 1;
    return 0;
  endfunction

  function automatic bit rob_live(input logic [RW-1:0] r);
    foreach (model_q[k]) if (model_q[k].rob == r) return 1;
    return 0;
  endfunction

  task automatic cyc_start();
    @(posedge clock);
    #1;
    reset           = 1'b0;
    bus.en          = 1'b1;
    bus.dispatch_en = 1'b0;
    bus.cdb_valid   = '0;
    bus.rollback_en = 1'b0;
    bus.fu_ready    = '1;
  endtask

  task automatic disp(input int fu, input int rob, input int t1, input bit r1, input int t2,
                      input bit r2);
    bus.dispatch_en       = 1'b1;
    bus.dispatch_fu       = 2'(fu);
    bus.dispatch_rob_idx  = RW'(rob);
    bus.dispatch_T_idx    = PW'(rob + 32);
    bus.dispatch_T1_idx   = PW'(t1);
    bus.dispatch_T1_ready = r1;
    bus.dispatch_T2_idx   = PW'(t2);
    bus.dispatch_T2_ready = r2;
    bus.dispatch_payload  = {$urandom, $urandom};
  endtask

  // Reference model: expected outputs this cycle, then the op set after the edge.
  task automatic cyc_eval();
    cyc_exp_t      ce;
    iss_exp_t      ie;
    op_t           nq[$];
    op_t           op;
    int            sel[NF];
    bit            sq[$];
    logic [RW-1:0] rb_age;
    rb_age  = age(bus.rollback_idx);
    ce.chk  = !reset;
    ce.cyc  = cyc_n;
    ce.occ  = 4'(model_q.size());
    ce.drdy = (model_q.size() < NE) && !bus.rollback_en;
    ce.vld  = '0;
    for (int f = 0; f < NF; f++) sel[f] = -1;
    foreach (model_q[k]) begin
      bit s, ok;
      int fc;
      s  = bus.rollback_en && (age(model_q[k].rob) >= rb_age);
      sq.push_back(s);
      ok = !s && (model_q[k].r1 || (Bypass && hit(model_q[k].t1)))
              && (model_q[k].r2 || (Bypass && hit(model_q[k].t2)));
      fc = int'(model_q[k].fu);
      if (ok && (sel[fc] < 0 || age(model_q[k].rob) < age(model_q[sel[fc]].rob))) sel[fc] = k;
    end
    for (int f = 0; f < NF; f++) begin
      ce.vld[f] = (sel[f] >= 0);
      if (ce.chk && sel[f] >= 0) begin
        op        = model_q[sel[f]];
        ie.cyc    = cyc_n;
        ie.f      = f;
        ie.fields = {op.rob, op.t, op.t1, op.t2, op.pay};
        iss_q.push_back(ie);
      end
    end
    cyc_q.push_back(ce);
    if (reset) begin
      model_q.delete();
    end else if (bus.en) begin
      foreach (model_q[k]) begin
        bit fired;
        fired = (sel[model_q[k].fu] == k) && bus.fu_ready[model_q[k].fu];
        if (!sq[k] && !fired) begin
          op    = model_q[k];
          op.r1 = op.r1 | hit(op.t1);
          op.r2 = op.r2 | hit(op.t2);
          nq.push_back(op);
        end
      end
      if (bus.dispatch_en && ce.drdy) begin
        op.fu  = bus.dispatch_fu;
        op.rob = bus.dispatch_rob_idx;
        op.t   = bus.dispatch_T_idx;
        op.t1  = bus.dispatch_T1_idx;
        op.t2  = bus.dispatch_T2_idx;
        op.r1  = bus.dispatch_T1_ready | hit(bus.dispatch_T1_idx);
        op.r2  = bus.dispatch_T2_ready | hit(bus.dispatch_T2_idx);
        op.pay = bus.dispatch_payload;
        nq.push_back(op);
      end
      model_q = nq;
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc_start();
      cyc_eval();
    end
  endtask

  task automatic do_reset();
    repeat (2) begin
      cyc_start();
      reset = 1'b1;
      cyc_eval();
    end
  endtask

  // Monitor: compares status every cycle and each presented op against the scoreboard.
  initial begin
    cyc_exp_t      ce;
    iss_exp_t      ie;
    logic [FW-1:0] act;
    forever begin
      @(negedge clock);
      while (cyc_q.size() > 0) begin
        ce = cyc_q.pop_front();
        if (ce.chk) begin
          chk("issue_valid", 128'(bus.issue_valid), 128'(ce.vld), ce.cyc);
          chk("occupancy", 128'(bus.occupancy), 128'(ce.occ), ce.cyc);
          chk("dispatch_ready", 128'(bus.dispatch_ready), 128'(ce.drdy), ce.cyc);
          for (int f = 0; f < NF; f++) begin
            if (bus.issue_valid[f] === 1'b1) begin
              act = {bus.issue_rob_idx[f*RW +: RW], bus.issue_T_idx[f*PW +: PW],
                     bus.issue_T1_idx[f*PW +: PW], bus.issue_T2_idx[f*PW +: PW],
                     bus.issue_payload[f*DW +: DW]};
              if (iss_q.size() > 0 && iss_q[0].cyc == ce.cyc && iss_q[0].f == f) begin
                ie = iss_q.pop_front();
                chk("issue_fields", 128'(act), 128'(ie.fields), ce.cyc);
              end else begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected cycle %0d class %0d: got op %0h expected none",
                         ce.cyc, f, act);
              end
            end
          end
        end
        while (iss_q.size() > 0 && iss_q[0].cyc <= ce.cyc) begin
          ie = iss_q.pop_front();
          checks++;
          errors++;
          $display("FAIL issue_missing cycle %0d class %0d: got none expected op %0h",
                   ie.cyc, ie.f, ie.fields);
        end
      end
    end
  end

  initial begin
    logic [RW-1:0] r;
    reset                 = 1'b1;
    bus.en                = 1'b1;
    bus.dispatch_en       = 1'b0;
    bus.dispatch_fu       = '0;
    bus.dispatch_rob_idx  = '0;
    bus.dispatch_T_idx    = '0;
    bus.dispatch_T1_idx   = '0;
    bus.dispatch_T2_idx   = '0;
    bus.dispatch_T1_ready = 1'b0;
    bus.dispatch_T2_ready = 1'b0;
    bus.dispatch_payload  = '0;
    bus.cdb_valid         = '0;
    bus.cdb_T_idx         = '0;
    bus.rob_head          = '0;
    bus.rollback_en       = 1'b0;
    bus.rollback_idx      = '0;
    bus.fu_ready          = '0;

    // Single ALU op: issues the cycle after dispatch.
    do_reset();
    cyc_start(); disp(0, 3, 1, 1, 2, 1); cyc_eval();
    idle(2);

    // Oldest-first with and without ROB wrap.
    for (int h = 0; h < 2; h++) begin
      do_reset();
      bus.rob_head = (h == 0) ? RW'(1) : RW'(6);
      cyc_start(); bus.fu_ready = '0; disp(0, 7, 1, 1, 2, 1); cyc_eval();
      cyc_start(); bus.fu_ready = '0; disp(0, 2, 1, 1, 2, 1); cyc_eval();
      idle(3);
    end

    // CDB wakeup of T1=12.
    do_reset();
    bus.rob_head = '0;
    cyc_start(); disp(1, 10, 12, 0, 2, 1); cyc_eval();
    idle(2);
    cyc_start(); bus.cdb_valid = 2'b01; bus.cdb_T_idx = {PW'(0), PW'(12)}; cyc_eval();
    idle(2);

    // Fill, ignored extra dispatch, one issue, then reuse.
    do_reset();
    for (int i = 0; i < NE; i++) begin
      cyc_start(); bus.fu_ready = '0; disp(i % NF, i, 1, 1, 2, 1); cyc_eval();
    end
    cyc_start(); bus.fu_ready = '0; disp(0, 20, 1, 1, 2, 1); cyc_eval();
    cyc_start(); bus.fu_ready = 4'b0001; disp(0, 20, 1, 1, 2, 1); cyc_eval();
    cyc_start(); bus.fu_ready = '0; disp(0, 20, 1, 1, 2, 1); cyc_eval();
    idle(4);

    // Rollback squashes rob 6 and 9 relative to head 4.
    do_reset();
    bus.rob_head = RW'(4);
    cyc_start(); bus.fu_ready = '0; disp(2, 4, 30, 0, 2, 1); cyc_eval();
    cyc_start(); bus.fu_ready = '0; disp(2, 5, 30, 0, 2, 1); cyc_eval();
    cyc_start(); bus.fu_ready = '0; disp(2, 6, 1, 1, 2, 1); cyc_eval();
    cyc_start(); bus.fu_ready = '0; disp(2, 9, 1, 1, 2, 1); cyc_eval();
    cyc_start(); bus.rollback_en = 1'b1; bus.rollback_idx = RW'(6); cyc_eval();
    idle(1);
    cyc_start(); bus.cdb_valid = 2'b10; bus.cdb_T_idx = {PW'(30), PW'(0)}; cyc_eval();
    idle(3);

    // Stall with stable fields, then reset mid-stall.
    do_reset();
    cyc_start(); disp(3, 1, 1, 1, 2, 1); cyc_eval();
    repeat (3) begin
      cyc_start(); bus.fu_ready = '0; cyc_eval();
    end
    cyc_start(); bus.fu_ready = '0; reset = 1'b1; cyc_eval();
    idle(2);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      cyc_start();
      reset        = ($urandom_range(0, 199) == 0);
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.rob_head = RW'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        do r = RW'($urandom); while (rob_live(r));
        disp($urandom_range(0, NF - 1), int'(r), $urandom_range(0, 15), 1'($urandom),
             $urandom_range(0, 15), 1'($urandom));
      end
      bus.cdb_valid    = 2'($urandom);
      bus.cdb_T_idx    = {PW'($urandom_range(0, 15)), PW'($urandom_range(0, 15))};
      bus.rollback_en  = ($urandom_range(0, 19) == 0);
      bus.rollback_idx = RW'($urandom);
      bus.fu_ready     = 4'($urandom) | 4'($urandom);
      cyc_eval();
    end

    @(negedge clock);
    #1;
    chk("leftover_issue_records", 128'(iss_q.size()), 128'(0), cyc_n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
